// File: rtl/write_channel_arbiter.sv
// write_channel_arbiter: picks one of NUM_PORTS write-request channels per cycle
// (round-robin or fixed priority) and forwards its word to the SRAM write
// controller through a registered valid/ready output stage.
module write_channel_arbiter #(
    parameter int NUM_PORTS      = 16,
    parameter int DATA_WIDTH     = 256,
    parameter int PRIORITY_MODE  = 0,
    localparam int SEL_WIDTH     = $clog2(NUM_PORTS)
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            enable,
    input  logic [NUM_PORTS-1:0]            req_valid,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0] req_data,
    output logic [NUM_PORTS-1:0]            req_ready,
    output logic                            out_valid,
    output logic [DATA_WIDTH-1:0]           out_data,
    output logic [SEL_WIDTH-1:0]            out_port,
    input  logic                            out_ready,
    output logic [SEL_WIDTH-1:0]            last_grant
);

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t                 state;
    state_t                 state_next;
    logic                   cap;
    logic                   load;
    logic                   drain;
    logic [SEL_WIDTH-1:0]   winner;
    logic [SEL_WIDTH-1:0]   rr_idx;
    logic [DATA_WIDTH-1:0]  winner_data;

    // A word is taken whenever the output register is free or being emptied this
    // cycle; reset blocks it so no source believes a word was accepted and then lost.
    assign cap = !rst && enable && (|req_valid) && ((state == IDLE) || out_ready);

    assign out_valid = (state == HOLD);

    // Winner search: lowest index in fixed mode, otherwise the first requester at or
    // after last_grant+1 (descending scan so the nearest offset is written last).
    always_comb begin
        winner = '0;
        rr_idx = '0;
        if (PRIORITY_MODE != 0) begin
            for (int i = NUM_PORTS - 1; i >= 0; i--) begin
                if (req_valid[i]) begin
                    winner = SEL_WIDTH'(i);
                end
            end
        end else begin
            for (int k = NUM_PORTS; k >= 1; k--) begin
                rr_idx = SEL_WIDTH'((int'(last_grant) + k) % NUM_PORTS);
                if (req_valid[rr_idx]) begin
                    winner = rr_idx;
                end
            end
        end
    end

    // Select the winning port's word and form the one-hot accept.
    always_comb begin
        winner_data = '0;
        req_ready   = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (winner == SEL_WIDTH'(i)) begin
                winner_data  = req_data[i*DATA_WIDTH +: DATA_WIDTH];
                req_ready[i] = cap;
            end
        end
    end

    // Next-state logic: load on capture, drain when the held word leaves with nothing behind it.
    always_comb begin
        state_next = state;
        load       = 1'b0;
        drain      = 1'b0;
        case (state)
            IDLE: begin
                if (cap) begin
                    load       = 1'b1;
                    state_next = HOLD;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    if (cap) begin
                        load = 1'b1;
                    end else begin
                        drain      = 1'b1;
                        state_next = IDLE;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Output stage and grant history; out_port and last_grant persist across idle periods.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_data   <= '0;
            out_port   <= '0;
            last_grant <= SEL_WIDTH'(NUM_PORTS - 1);
        end else if (load) begin
            out_data   <= winner_data;
            out_port   <= winner;
            last_grant <= winner;
        end else if (drain) begin
            out_data   <= '0;
        end
    end

endmodule

// File: tb/tb_write_channel_arbiter.sv
// tb_write_channel_arbiter: drives three arbiter builds (16-port round-robin,
// 16-port fixed priority, 5-port round-robin) and checks them against a
// cycle model with a scoreboard of expected forwarded words.
module tb_write_channel_arbiter;

    localparam int DW  = 32;
    localparam int NP  = 16;
    localparam int NP5 = 5;

    typedef struct {
        int            port;
        logic [DW-1:0] data;
    } sb_item_t;

    typedef struct {
        logic [NP-1:0] rv;
        logic          en;
        logic          ordy;
        logic [NP-1:0] exp_ready;
    } vec_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             enable = 1'b0;
    logic             out_ready = 1'b0;
    logic [NP-1:0]    req_valid = '0;
    logic [NP*DW-1:0] req_data = '0;

    logic [NP-1:0]    rr_req_ready;
    logic             rr_out_valid;
    logic [DW-1:0]    rr_out_data;
    logic [3:0]       rr_out_port;
    logic [3:0]       rr_last_grant;

    logic [NP-1:0]    fp_req_ready;
    logic             fp_out_valid;
    logic [DW-1:0]    fp_out_data;
    logic [3:0]       fp_out_port;
    logic [3:0]       fp_last_grant;

    logic [NP5-1:0]   p5_req_ready;
    logic             p5_out_valid;
    logic [DW-1:0]    p5_out_data;
    logic [2:0]       p5_out_port;
    logic [2:0]       p5_last_grant;

    int               dut_sel = 0;
    int               cur_n;
    int               cur_mode;
    logic [NP-1:0]    cur_req_ready;
    logic             cur_out_valid;
    logic [DW-1:0]    cur_out_data;
    int               cur_out_port;
    int               cur_last_grant;

    int               errors = 0;
    int               checks = 0;
    bit               m_hold;
    int               m_last;
    sb_item_t         sb_q[$];

    write_channel_arbiter #(.NUM_PORTS(NP), .DATA_WIDTH(DW), .PRIORITY_MODE(0)) dut_rr (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_ready  (rr_req_ready),
        .out_valid  (rr_out_valid),
        .out_data   (rr_out_data),
        .out_port   (rr_out_port),
        .out_ready  (out_ready),
        .last_grant (rr_last_grant)
    );

    write_channel_arbiter #(.NUM_PORTS(NP), .DATA_WIDTH(DW), .PRIORITY_MODE(1)) dut_fp (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_ready  (fp_req_ready),
        .out_valid  (fp_out_valid),
        .out_data   (fp_out_data),
        .out_port   (fp_out_port),
        .out_ready  (out_ready),
        .last_grant (fp_last_grant)
    );

    write_channel_arbiter #(.NUM_PORTS(NP5), .DATA_WIDTH(DW), .PRIORITY_MODE(0)) dut_p5 (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .req_valid  (req_valid[NP5-1:0]),
        .req_data   (req_data[NP5*DW-1:0]),
        .req_ready  (p5_req_ready),
        .out_valid  (p5_out_valid),
        .out_data   (p5_out_data),
        .out_port   (p5_out_port),
        .out_ready  (out_ready),
        .last_grant (p5_last_grant)
    );

    always #5 clk = ~clk;

    // Route the outputs of whichever build is under test onto common observation signals.
    always_comb begin
        cur_n          = NP;
        cur_mode       = 0;
        cur_req_ready  = rr_req_ready;
        cur_out_valid  = rr_out_valid;
        cur_out_data   = rr_out_data;
        cur_out_port   = int'(rr_out_port);
        cur_last_grant = int'(rr_last_grant);
        if (dut_sel == 1) begin
            cur_mode       = 1;
            cur_req_ready  = fp_req_ready;
            cur_out_valid  = fp_out_valid;
            cur_out_data   = fp_out_data;
            cur_out_port   = int'(fp_out_port);
            cur_last_grant = int'(fp_last_grant);
        end else if (dut_sel == 2) begin
            cur_n          = NP5;
            cur_req_ready  = {{(NP-NP5){1'b0}}, p5_req_ready};
            cur_out_valid  = p5_out_valid;
            cur_out_data   = p5_out_data;
            cur_out_port   = int'(p5_out_port);
            cur_last_grant = int'(p5_last_grant);
        end
    end

    function automatic logic [DW-1:0] word_of(input int i);
        return 32'hC0DE_0000 + (DW'(i) * 32'h0000_0111);
    endfunction

    function automatic int model_winner(input logic [NP-1:0] rv, input int last, input int n, input int mode);
        int p;
        if (mode == 1) begin
            for (int i = 0; i < n; i++) begin
                if (((rv >> i) & NP'(1)) != '0) return i;
            end
        end else begin
            for (int k = 1; k <= n; k++) begin
                p = (last + k) % n;
                if (((rv >> p) & NP'(1)) != '0) return p;
            end
        end
        return -1;
    endfunction

    task automatic checkOutput(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic doReset();
        rst = 1'b1;
        enable = 1'b0;
        out_ready = 1'b0;
        req_valid = '0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        m_hold = 1'b0;
        m_last = cur_n - 1;
        sb_q.delete();
        checkOutput("rst_out_valid", DW'(cur_out_valid), '0);
        checkOutput("rst_out_data", cur_out_data, '0);
        checkOutput("rst_out_port", DW'(cur_out_port), '0);
        checkOutput("rst_last_grant", DW'(cur_last_grant), DW'(cur_n - 1));
    endtask

    // One clock of stimulus: drive, compare against the model at the falling edge, advance.
    task automatic applyStimulus(input logic [NP-1:0] rv, input logic en, input logic ordy,
                                 output logic [NP-1:0] seen);
        logic [NP-1:0] one;
        logic [NP-1:0] mask;
        logic [NP-1:0] rvm;
        logic [NP-1:0] exp_ready;
        logic          cap;
        int            w;
        sb_item_t      item;
        req_valid = rv;
        enable    = en;
        out_ready = ordy;
        @(negedge clk);
        one  = NP'(1);
        mask = (cur_n >= NP) ? '1 : ((one << cur_n) - one);
        rvm  = rv & mask;
        cap  = en && (rvm != '0) && (!m_hold || ordy);
        w    = model_winner(rvm, m_last, cur_n, cur_mode);
        exp_ready = cap ? (one << w) : '0;
        seen = cur_req_ready;
        checkOutput("req_ready", DW'(cur_req_ready), DW'(exp_ready));
        checkOutput("out_valid", DW'(cur_out_valid), DW'(m_hold));
        checkOutput("last_grant", DW'(cur_last_grant), DW'(m_last));
        if (m_hold) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL scoreboard_empty: got no expected word, expected one queued");
            end else begin
                item = sb_q[0];
                checkOutput("out_port", DW'(cur_out_port), DW'(item.port));
                checkOutput("out_data", cur_out_data, item.data);
                if (ordy) void'(sb_q.pop_front());
            end
        end else begin
            checkOutput("out_data_idle", cur_out_data, '0);
        end
        if (cap) begin
            item.port = w;
            item.data = word_of(w);
            sb_q.push_back(item);
            m_hold = 1'b1;
            m_last = w;
        end else if (m_hold && ordy) begin
            m_hold = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    vec_t          tbl[11];
    logic [NP-1:0] seen;
    logic [NP-1:0] exp_v;

    initial begin
        for (int i = 0; i < NP; i++) begin
            req_data[i*DW +: DW] = word_of(i);
        end

        tbl[0]  = '{16'h0001, 1'b1, 1'b1, 16'h0001};
        tbl[1]  = '{16'h0000, 1'b1, 1'b1, 16'h0000};
        tbl[2]  = '{16'h0012, 1'b1, 1'b0, 16'h0002};
        tbl[3]  = '{16'h0012, 1'b1, 1'b0, 16'h0000};
        tbl[4]  = '{16'h0012, 1'b1, 1'b1, 16'h0010};
        tbl[5]  = '{16'h0012, 1'b1, 1'b1, 16'h0002};
        tbl[6]  = '{16'h8000, 1'b0, 1'b1, 16'h0000};
        tbl[7]  = '{16'h8000, 1'b1, 1'b0, 16'h8000};
        tbl[8]  = '{16'h8001, 1'b1, 1'b1, 16'h0001};
        tbl[9]  = '{16'h8001, 1'b1, 1'b1, 16'h8000};
        tbl[10] = '{16'h0000, 1'b1, 1'b1, 16'h0000};

        // Table vectors on the round-robin build, starting from reset.
        dut_sel = 0;
        #1;
        doReset();
        for (int v = 0; v < 11; v++) begin
            applyStimulus(tbl[v].rv, tbl[v].en, tbl[v].ordy, seen);
            checkOutput($sformatf("tbl%0d_req_ready", v), DW'(seen), DW'(tbl[v].exp_ready));
        end

        // All sixteen ports requesting: grants rotate 0..15 then 0 with no bubble.
        doReset();
        for (int k = 0; k < 17; k++) begin
            applyStimulus(16'hFFFF, 1'b1, 1'b1, seen);
            exp_v = NP'(1) << (k % NP);
            checkOutput($sformatf("rr_all_grant%0d", k), DW'(seen), DW'(exp_v));
        end
        applyStimulus(16'h0000, 1'b1, 1'b1, seen);
        applyStimulus(16'h0000, 1'b1, 1'b1, seen);

        // Backpressure: port 5's word stays frozen for four cycles, then port 9 follows.
        doReset();
        applyStimulus(16'h0020, 1'b1, 1'b0, seen);
        checkOutput("bp_first_grant", DW'(seen), 32'h0000_0020);
        for (int k = 0; k < 4; k++) begin
            applyStimulus(16'h0220, 1'b1, 1'b0, seen);
            checkOutput($sformatf("bp_no_accept%0d", k), DW'(seen), '0);
        end
        applyStimulus(16'h0220, 1'b1, 1'b1, seen);
        checkOutput("bp_next_grant", DW'(seen), 32'h0000_0200);
        applyStimulus(16'h0000, 1'b1, 1'b1, seen);

        // Fixed priority: port 3 always beats port 9.
        dut_sel = 1;
        #1;
        doReset();
        for (int k = 0; k < 6; k++) begin
            applyStimulus(16'h0208, 1'b1, 1'b1, seen);
            checkOutput($sformatf("fp_grant%0d", k), DW'(seen), 32'h0000_0008);
        end
        applyStimulus(16'h0000, 1'b1, 1'b1, seen);

        // Enable dropped while a word is held: it drains and nothing more is granted.
        dut_sel = 0;
        #1;
        doReset();
        applyStimulus(16'h0040, 1'b1, 1'b0, seen);
        applyStimulus(16'h00FF, 1'b0, 1'b0, seen);
        applyStimulus(16'h00FF, 1'b0, 1'b1, seen);
        for (int k = 0; k < 3; k++) begin
            applyStimulus(16'h00FF, 1'b0, 1'b1, seen);
            checkOutput($sformatf("en_off_grant%0d", k), DW'(seen), '0);
        end

        // Reset in the middle of a held word: word discarded, search restarts at port 0.
        doReset();
        applyStimulus(16'h0400, 1'b1, 1'b1, seen);
        checkOutput("mid_rst_first_grant", DW'(seen), 32'h0000_0400);
        applyStimulus(16'h0100, 1'b1, 1'b0, seen);
        rst = 1'b1;
        enable = 1'b1;
        out_ready = 1'b0;
        req_valid = 16'h0506;
        @(negedge clk);
        checkOutput("mid_rst_ready_in_reset", DW'(cur_req_ready), '0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        m_hold = 1'b0;
        m_last = cur_n - 1;
        sb_q.delete();
        checkOutput("mid_rst_out_valid", DW'(cur_out_valid), '0);
        checkOutput("mid_rst_last_grant", DW'(cur_last_grant), 32'd15);
        applyStimulus(16'h0506, 1'b1, 1'b1, seen);
        checkOutput("mid_rst_regrant", DW'(seen), 32'h0000_0002);
        applyStimulus(16'h0000, 1'b1, 1'b1, seen);

        // Five-port build: wrap from last_grant=4 back to port 0.
        dut_sel = 2;
        #1;
        doReset();
        applyStimulus(16'h0011, 1'b1, 1'b1, seen);
        checkOutput("p5_wrap_grant", DW'(seen), 32'h0000_0001);
        applyStimulus(16'h0011, 1'b1, 1'b1, seen);
        checkOutput("p5_second_grant", DW'(seen), 32'h0000_0010);
        applyStimulus(16'h0011, 1'b1, 1'b1, seen);
        checkOutput("p5_third_grant", DW'(seen), 32'h0000_0001);
        applyStimulus(16'h0000, 1'b1, 1'b1, seen);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
